// File: rtl/mult_div_unit.sv
// mult_div_unit
// -----------------------------------------------------------------------------
// Multicycle HI/LO unit that sits beside the MIPS ALU. It is driven by the same
// ALUOp/ALUFunction pair as the ALU and recognises the R-type funct codes
// MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
//
// Multiplication is an iterative shift-add, and division is a restoring divide.
// Both retire one bit per clock and work on operand magnitudes. Signs are
// applied in a final FIX cycle, which also writes HI and LO together.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   Start        qualifies ALUOp/ALUFunction/operands this cycle
//   ALUOp[2:0]   must be 3'b111 (R-type) for any action
//   ALUFunction  funct field
//   ReadData1    rs operand (multiplicand / dividend / MTxx source)
//   ReadData2    rt operand (multiplier / divisor)
//   HI, LO       architectural HI/LO registers
//   MFResult     combinational: HI on MFHI, LO on MFLO, otherwise 0
//   Busy         operation in flight; the control unit must stall
//   Done         one-cycle pulse after HI/LO were written by a mult/div
//   DivByZero    one-cycle pulse with Done when the divisor was zero
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       ALUFunction,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MFResult,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_RTYPE = 3'b111;
    localparam logic [5:0] F_MULT   = 6'b011000;
    localparam logic [5:0] F_MULTU  = 6'b011001;
    localparam logic [5:0] F_DIV    = 6'b011010;
    localparam logic [5:0] F_DIVU   = 6'b011011;
    localparam logic [5:0] F_MFHI   = 6'b010000;
    localparam logic [5:0] F_MTHI   = 6'b010001;
    localparam logic [5:0] F_MFLO   = 6'b010010;
    localparam logic [5:0] F_MTLO   = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    // For a multiply, acc_hi/acc_lo hold the running product; acc_lo starts as
    // the multiplier. For a divide, acc_hi holds the partial remainder and
    // acc_lo holds the dividend, which is shifted out as the quotient is
    // shifted in.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;        // negate product / quotient
    logic             rneg_q, rneg_d;      // negate remainder (dividend sign)
    logic             dbz_q, dbz_d;        // divisor was zero
    logic             done_q, done_d;
    logic             dbz_out_q, dbz_out_d;

    // Instruction decode
    logic             rtype;
    logic             op_md, op_div, op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign rtype     = Start && (ALUOp == OP_RTYPE);
    assign op_div    = (ALUFunction == F_DIV) || (ALUFunction == F_DIVU);
    assign op_md     = op_div || (ALUFunction == F_MULT) || (ALUFunction == F_MULTU);
    assign op_signed = (ALUFunction == F_MULT) || (ALUFunction == F_DIV);
    assign a_neg     = op_signed && ReadData1[WIDTH-1];
    assign b_neg     = op_signed && ReadData2[WIDTH-1];
    // The unsigned magnitude of MIN_INT is 2^(WIDTH-1), which is what the
    // two's-complement negation yields.
    assign a_mag     = a_neg ? (~ReadData1 + 1'b1) : ReadData1;
    assign b_mag     = b_neg ? (~ReadData2 + 1'b1) : ReadData2;

    // One iteration of the datapath
    logic [WIDTH:0]     add_sum;     // shift-add partial sum, includes carry
    logic [WIDTH:0]     rem_shift;   // remainder shifted left with next dividend bit
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd_q};
    assign prod_mag  = {acc_hi_q, acc_lo_q};
    assign prod_fix  = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    assign quo_fix   = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    assign rem_fix   = rneg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rtype) begin
                    if (op_md) begin
                        cnt_d    = '0;
                        is_div_d = op_div;
                        neg_d    = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        dbz_d    = 1'b0;
                        acc_hi_d = '0;
                        state_d  = S_RUN;
                        if (op_div) begin
                            acc_lo_d = a_mag;
                            opnd_d   = b_mag;
                            if (ReadData2 == '0) begin
                                // Skip the iterations. HI receives the raw
                                // dividend in FIX.
                                dbz_d    = 1'b1;
                                acc_hi_d = ReadData1;
                                state_d  = S_FIX;
                            end
                        end else begin
                            acc_lo_d = b_mag;
                            opnd_d   = a_mag;
                        end
                    end else if (ALUFunction == F_MTHI) begin
                        hi_d = ReadData1;
                    end else if (ALUFunction == F_MTLO) begin
                        lo_d = ReadData1;
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    // Restoring step: keep the difference only if it is
                    // non-negative.
                    if (!rem_diff[WIDTH]) begin
                        acc_hi_d = rem_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Add the multiplicand into the upper half when the
                    // multiplier LSB is set. Then shift the 2*WIDTH-bit
                    // product right, keeping the carry.
                    acc_hi_d = add_sum[WIDTH:1];
                    acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (dbz_q) begin
                    hi_d = acc_hi_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    // The move-from path is a plain read of the architectural registers, so it
    // stays valid while an operation is in flight.
    always_comb begin
        MFResult = '0;
        if (ALUOp == OP_RTYPE) begin
            if (ALUFunction == F_MFHI) begin
                MFResult = hi_q;
            end else if (ALUFunction == F_MFLO) begin
                MFResult = lo_q;
            end
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_out_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit (WIDTH=32). It applies directed and randomised
// mult/div operations and checks them against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic [2:0]   ALUOp;
    logic [5:0]   ALUFunction;
    logic [W-1:0] ReadData1, ReadData2;
    logic [W-1:0] HI, LO, MFResult;
    logic         Busy, Done, DivByZero;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .Start       (Start),
        .ALUOp       (ALUOp),
        .ALUFunction (ALUFunction),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .HI          (HI),
        .LO          (LO),
        .MFResult    (MFResult),
        .Busy        (Busy),
        .Done        (Done),
        .DivByZero   (DivByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: MIPS HI/LO results computed with plain 64-bit arithmetic.
    task automatic ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        ed = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = '0;
        el = '0;
        case (f)
            F_MULT: begin
                sp = sa * sb;
                eh = sp[63:32];
                el = sp[31:0];
            end
            F_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            default: begin
                if (b == 0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                    ed = 1'b1;
                end else if (f == F_DIV) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    eh = sr[31:0];
                    el = sq[31:0];
                end else begin
                    eh = a % b;
                    el = a / b;
                end
            end
        endcase
    endtask

    // Issue one mult/div at the current (negedge) time and follow it to Done.
    // If "interfere" is set, an MTHI and a second MULT are attempted while the
    // unit is busy, and MFHI is read mid-operation.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input bit interfere);
        logic [31:0] eh, el, old_hi;
        logic        ed;
        int          busy_n, done_k, exp_busy;
        bit          seen;
        ref_op(f, a, b, eh, el, ed);
        exp_busy    = ed ? 1 : W + 1;
        old_hi      = HI;
        ALUOp       = 3'b111;
        ALUFunction = f;
        ReadData1   = a;
        ReadData2   = b;
        Start       = 1'b1;
        busy_n      = 0;
        done_k      = 0;
        seen        = 1'b0;
        for (int k = 1; k <= 80 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) Start = 1'b0;
            if (Busy) busy_n++;
            if (Done) begin
                seen   = 1'b1;
                done_k = k;
            end
            if (interfere) begin
                if (k == 4) begin
                    ALUFunction = F_MTHI; ReadData1 = 32'h0000_1234; Start = 1'b1;
                end else if (k == 5) begin
                    ALUFunction = F_MULT; ReadData1 = 32'd7; ReadData2 = 32'd9; Start = 1'b1;
                end else if (k == 6) begin
                    ALUFunction = F_MFHI; Start = 1'b1;
                    #1;
                    check({tag, "_mfhi_busy"}, MFResult, old_hi);
                    check({tag, "_hi_hold"}, HI, old_hi);
                    Start = 1'b0;
                end
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_busy_cycles"}, busy_n, exp_busy);
            check({tag, "_done_cycle"}, done_k, exp_busy + 1);
            check({tag, "_busy_at_done"}, Busy, 0);
            check({tag, "_hi"}, HI, eh);
            check({tag, "_lo"}, LO, el);
            check({tag, "_dbz"}, DivByZero, ed);
        end
        ALUFunction = F_MFLO;
        Start       = 1'b1;
        #1;
        check({tag, "_mflo"}, MFResult, el);
        ALUFunction = F_MFHI;
        #1;
        check({tag, "_mfhi"}, MFResult, eh);
        Start = 1'b0;
        $display("[TB] %s f=%b a=%h b=%h -> HI=%h LO=%h dbz=%b busy=%0d done@%0d",
                 tag, f, a, b, HI, LO, DivByZero, busy_n, done_k);
    endtask

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra, rb;
        int          done_cnt;
        logic [5:0]  fsel [4];
        fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV; fsel[3] = F_DIVU;

        reset = 1'b0; Start = 1'b0; ALUOp = 3'b000; ALUFunction = '0;
        ReadData1 = '0; ReadData2 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_dbz", DivByZero, 0);
        reset = 1'b1;
        @(negedge clk);

        // Directed operations from the test plan
        run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        @(negedge clk);
        check("done_pulse_width", Done, 0);
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("multu_b2b", F_MULTU, 32'd3, 32'd5, 1'b0);
        run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 1'b0);
        run_op("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_5_0", F_DIV, 32'd5, 32'd0, 1'b0);
        @(negedge clk);
        check("dbz_pulse_width", DivByZero, 0);
        run_op("mult_interfere", F_MULT, 32'h0001_2345, 32'hFFFF_0003, 1'b1);

        // Randomised operations, including some zero divisors
        for (int i = 0; i < 16; i++) begin
            rf = fsel[$urandom_range(0, 3)];
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            if ($urandom_range(0, 3) == 0) ra = -ra;
            run_op($sformatf("rand%0d", i), rf, ra, rb, 1'b0);
        end

        // Asynchronous reset in the middle of a divide aborts it
        run_op("pre_reset", F_DIVU, 32'd1000, 32'd33, 1'b0);
        ALUOp = 3'b111; ALUFunction = F_DIV; ReadData1 = 32'hFFFF_FF9C; ReadData2 = 32'd3;
        Start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            Start = 1'b0;
        end
        check("mid_div_busy", Busy, 1);
        #3 reset = 1'b0;
        #1;
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        check("abort_busy", Busy, 0);
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (Done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        $display("[TB] reset abort: HI=%h LO=%h done_count=%0d", HI, LO, done_cnt);

        // MTLO in IDLE is written at the next edge, with no Busy and no Done
        ALUOp = 3'b111; ALUFunction = F_MTLO; ReadData1 = 32'h0000_ABCD; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("mtlo_lo", LO, 32'h0000_ABCD);
        check("mtlo_hi", HI, 0);
        check("mtlo_busy", Busy, 0);
        check("mtlo_done", Done, 0);
        $display("[TB] mtlo: LO=%h", LO);

        // MTHI with a non-R-type ALUOp is ignored
        ALUOp = 3'b000; ALUFunction = F_MTHI; ReadData1 = 32'h0000_0055; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("aluop_ignored_hi", HI, 0);
        $display("[TB] mthi with aluop=000: HI=%h", HI);

        // An unknown funct is ignored
        ALUOp = 3'b111; ALUFunction = 6'h3F; ReadData1 = 32'hDEAD_BEEF; ReadData2 = 32'd3;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        check("unk_hi", HI, 0);
        check("unk_lo", LO, 32'h0000_ABCD);
        check("unk_busy", Busy, 0);
        $display("[TB] unknown funct: HI=%h LO=%h busy=%b", HI, LO, Busy);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised, multicycle HI/LO unit for the MIPS datapath. It sits beside the ALU and is driven by the same ALUOp/ALUFunction pair the ALU control decodes.
- It decodes the R-type funct codes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Multiply runs as iterative shift-add and divide as restoring division, one bit per cycle.
- It raises Busy so the control unit stalls the pipeline/FSM until Done.

Parameters:
- WIDTH, 32, operand and HI/LO width. Legal range 4..64.
- CNT_W, $clog2(WIDTH+1), derived localparam. Iteration counter width; not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Start  input  1  qualifies ALUOp/ALUFunction/operands this cycle
- ALUOp  input  3  must equal 3'b111 (R-type) for any action
- ALUFunction  input  6  funct field
- ReadData1  input  WIDTH  rs operand (multiplicand / dividend / MTxx source)
- ReadData2  input  WIDTH  rt operand (multiplier / divisor)
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register
- MFResult  output  WIDTH  combinational: HI on MFHI, LO on MFLO, else 0
- Busy  output  1  operation in flight; control must stall
- Done  output  1  one-cycle pulse, HI/LO just updated by a mult/div
- DivByZero  output  1  one-cycle pulse coincident with Done when the divisor was 0

Behaviour:
- Reset (async, reset=0): HI=0, LO=0, Busy=0, Done=0, DivByZero=0, state=IDLE, counter=0.
  - Reset mid-operation aborts the operation; no Done is produced.
- Funct codes (ALUOp=111 only):
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
  - Any other funct/ALUOp combination with Start=1 is ignored; no state change.
- States:
  - IDLE: Busy=0.
  - RUN: iterate.
  - FIX: sign correction and HI/LO write.
- Accept: at an edge E0 with state=IDLE, Start=1 and mult/div funct:
  - latch operand magnitudes, signedness, op and result-sign flags;
  - counter=0; go to RUN (or FIX if the divisor is 0); Busy=1 from E0.
- RUN: one iteration per edge on E1..E_WIDTH.
  - Multiply: 2*WIDTH-bit shift-add on magnitudes.
  - Divide: restoring step on magnitudes.
  - After E_WIDTH, state=FIX.
- FIX, at edge E_{WIDTH+1}:
  - Write HI/LO atomically; go to IDLE; Busy=0.
  - Done=1 for exactly the following cycle.
  - Latency: Busy high WIDTH+1 cycles; Done in cycle WIDTH+2 after the Start cycle.
- Signed mult: negate the 2*WIDTH product if the operand signs differ; HI=upper half, LO=lower half.
- Signed div:
  - LO=quotient, truncated toward zero; HI=remainder carrying the sign of the dividend.
  - MIN_INT / -1 gives LO=MIN_INT, HI=0 (wraps, no flag).
- Divide by zero:
  - Skip RUN: E0 goes to FIX, E1 writes, Done at the next cycle (Busy 1 cycle).
  - HI=original dividend, LO=all ones, DivByZero=1 with Done.
- HI/LO are unchanged during RUN; old values stay readable via MFHI/MFLO until the FIX write.
- MTHI/MTLO with Start=1 in IDLE: write ReadData1 to HI/LO at that edge; no Busy, no Done.
- Start while Busy=1: ignored for every funct (including MTxx); the control unit must hold the instruction.
- MFResult is combinational and valid regardless of Busy.
- Start in the Done cycle: state is IDLE, so it is accepted normally (back-to-back operation).

Test Plan (WIDTH=32):
- MULT 0xFFFFFFFD × 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy 33 cycles; Done in cycle 34; MFLO then gives 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Back-to-back MULTU 3×5 issued in the Done cycle -> HI=0, LO=0x0F.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=0x0000000E, HI=0x00000002. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, DivByZero=0.
- DIV 5/0 -> Busy 1 cycle, Done and DivByZero pulse together, HI=0x00000005, LO=0xFFFFFFFF.
- During MULT, MTHI 0x1234 and a second MULT at cycle 5 -> both ignored; final HI/LO equal the first MULT's result; MFHI during Busy returns the pre-MULT HI.
- Assert reset=0 asynchronously (mid-clock) at cycle 10 of a DIV -> HI=LO=0 and Busy=0 immediately, no Done. MTLO 0xABCD afterwards -> LO=0xABCD next edge; unknown funct 0x3F with Start -> no change.
